// File: rtl/ram_responder_pkg.sv
// Shared sizing constants and FSM encoding for the RAM responder.
package ram_responder_pkg;

    localparam int RAM_DW    = 16;
    localparam int RAM_AW    = 6;
    localparam int RAM_DEPTH = 2 ** RAM_AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

endpackage

// File: rtl/ram_responder_if.sv
// Processor/loader bus of the RAM responder. The processor and loader side
// uses master. The RAM side uses slave.
interface ram_responder_if
    import ram_responder_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
);
    logic [15:0]   Daddress;
    logic [DW-1:0] Dout;
    logic          W;
    logic [DW-1:0] RData;
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [DW-1:0] LoadData;
    logic          Ready;
    logic          Overrun;
    logic          AddrErr;

    modport master (
        output Daddress, Dout, W, LoadEn, LoadAddr, LoadData,
        input  RData, Ready, Overrun, AddrErr
    );

    modport slave (
        input  Daddress, Dout, W, LoadEn, LoadAddr, LoadData,
        output RData, Ready, Overrun, AddrErr
    );
endinterface

// File: rtl/ram_responder_array.sv
// Storage array with one synchronous write port and one asynchronous read
// port. It has no reset. Contents are zeroed only by the responder's clear
// sweep.
module ram_sp_array
    import ram_responder_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];

    // Single write port. At most one word is updated per cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ram_responder.sv
// RAM responder. It runs a clear sweep after reset, then services the
// processor and the program loader. A one-entry pending buffer holds a
// processor write when the loader takes the write port.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_CLEAR | zeroing word[cnt] each cycle; accesses ignored, Ready=0
//   ST_SERVE | normal service until reset, Ready=1
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic           Clock,
    input  logic           Reset,
    ram_responder_if.slave bus
);
    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          overrun_q, overrun_d;
    logic          addr_err_q, addr_err_d;

    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_rdata;
    logic [AW-1:0] acc_idx;
    logic          in_range;
    logic          w_ok;

    // The same address serves the read and the processor write.
    assign acc_idx  = bus.Daddress[AW-1:0];
    assign in_range = (bus.Daddress[15:AW] == '0);

    ram_sp_array #(.DW(DW), .AW(AW)) u_array (
        .clk_i   (Clock),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i (acc_idx),
        .rdata_o (arr_rdata)
    );

    // Next state, write-port arbitration, pending buffer, flags and read value.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        overrun_d    = overrun_q;
        addr_err_d   = addr_err_q;
        rdata_d      = '0;
        arr_we       = 1'b0;
        arr_waddr    = cnt_q;
        arr_wdata    = '0;
        w_ok         = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                arr_we       = 1'b1;
                cnt_d        = cnt_q + AW'(1);
                pend_valid_d = 1'b0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                w_ok = bus.W && in_range;
                if (bus.W && !in_range) begin
                    addr_err_d = 1'b1;
                end

                // Loader owns the port. A pending entry drains when the loader is idle.
                if (bus.LoadEn) begin
                    arr_we    = 1'b1;
                    arr_waddr = bus.LoadAddr;
                    arr_wdata = bus.LoadData;
                    if (w_ok) begin
                        if (pend_valid_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            pend_valid_d = 1'b1;
                            pend_addr_d  = acc_idx;
                            pend_data_d  = bus.Dout;
                        end
                    end
                end else if (pend_valid_q) begin
                    arr_we       = 1'b1;
                    arr_waddr    = pend_addr_q;
                    arr_wdata    = pend_data_q;
                    pend_valid_d = w_ok;
                    if (w_ok) begin
                        pend_addr_d = acc_idx;
                        pend_data_d = bus.Dout;
                    end
                end else if (w_ok) begin
                    arr_we    = 1'b1;
                    arr_waddr = acc_idx;
                    arr_wdata = bus.Dout;
                end

                // Write-first read, newest source first. An accepted processor
                // write has the same address as the read, so it always wins.
                // After that comes the pending entry, then the loader, then the array.
                if (!in_range) begin
                    rdata_d = '0;
                end else if (w_ok && !(bus.LoadEn && pend_valid_q)) begin
                    rdata_d = bus.Dout;
                end else if (pend_valid_q && (pend_addr_q == acc_idx)) begin
                    rdata_d = pend_data_q;
                end else if (bus.LoadEn && (bus.LoadAddr == acc_idx)) begin
                    rdata_d = bus.LoadData;
                end else begin
                    rdata_d = arr_rdata;
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            rdata_q      <= '0;
            overrun_q    <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            rdata_q      <= rdata_d;
            overrun_q    <= overrun_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign bus.RData   = rdata_q;
    assign bus.Ready   = (state_q == ST_SERVE);
    assign bus.Overrun = overrun_q;
    assign bus.AddrErr = addr_err_q;
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder. A queue-based memory model predicts the outputs
// every cycle. Directed steps also carry hand-computed literal expectations.
module tb_ram_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_responder_if bus ();

    ram_responder dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    // Model: the backing store plus queued (not yet stored) processor writes.
    typedef struct {
        int unsigned a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] m_mem [64];
    wr_t         pq[$];
    int          clr_left;
    logic        m_ovr, m_aerr, m_valid = 1'b0;
    logic [15:0] m_rdata;

    function automatic logic [15:0] view(input int unsigned a);
        for (int i = pq.size() - 1; i >= 0; i--)
            if (pq[i].a == a) return pq[i].d;
        return m_mem[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_mem[i] = 16'h0;
            pq.delete();
            clr_left = 64;
            m_ovr    = 1'b0;
            m_aerr   = 1'b0;
            m_rdata  = 16'h0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (clr_left > 0) begin
                clr_left--;
                m_rdata = 16'h0;
            end else begin : serve
                int unsigned a;
                bit inr, acc;
                a   = bus.Daddress;
                inr = (a < 64);
                if (bus.W && !inr) m_aerr = 1'b1;
                acc = bus.W && inr && !(bus.LoadEn && pq.size() != 0);
                if (bus.W && inr && !acc) m_ovr = 1'b1;
                if (acc) pq.push_back('{a, bus.Dout});
                if (bus.LoadEn) m_mem[bus.LoadAddr] = bus.LoadData;
                else if (pq.size() != 0) begin
                    m_mem[pq[0].a] = pq[0].d;
                    pq.delete(0);
                end
                m_rdata = inr ? view(a) : 16'h0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rdata",   bus.RData,          m_rdata);
            chk("model_ready",   {15'h0, bus.Ready}, {15'h0, (clr_left == 0)});
            chk("model_overrun", {15'h0, bus.Overrun}, {15'h0, m_ovr});
            chk("model_addrerr", {15'h0, bus.AddrErr}, {15'h0, m_aerr});
        end
    end

    task automatic step(input logic [15:0] a, input logic w, input logic [15:0] d,
                        input logic le, input logic [5:0] la, input logic [15:0] ld);
        bus.Daddress = a;
        bus.W        = w;
        bus.Dout     = d;
        bus.LoadEn   = le;
        bus.LoadAddr = la;
        bus.LoadData = ld;
        @(negedge clk);
    endtask

    task automatic rd(input logic [15:0] a);
        step(a, 1'b0, 16'h0, 1'b0, 6'h0, 16'h0);
    endtask

    task automatic clear_and_sweep(input string tag);
        for (int k = 1; k <= 64; k++) begin
            rd(16'h0);
            if (k == 63) chk({tag, "_ready63"}, {15'h0, bus.Ready}, 16'h0);
            if (k == 64) chk({tag, "_ready64"}, {15'h0, bus.Ready}, 16'h1);
        end
        for (int i = 0; i < 64; i++) begin
            rd(16'(i));
            chk({tag, "_zero"}, bus.RData, 16'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.Daddress = '0; bus.W = 1'b0; bus.Dout = '0;
        bus.LoadEn = 1'b0; bus.LoadAddr = '0; bus.LoadData = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rdata",   bus.RData, 16'h0);
        chk("reset_ready",   {15'h0, bus.Ready}, 16'h0);
        chk("reset_overrun", {15'h0, bus.Overrun}, 16'h0);
        chk("reset_addrerr", {15'h0, bus.AddrErr}, 16'h0);
        rst = 1'b0;
        clear_and_sweep("init");

        // Direct write with same-cycle read, then a plain read.
        step(16'd5, 1'b1, 16'h1234, 1'b0, 6'd0, 16'h0);
        chk("wr5_same", bus.RData, 16'h1234);
        rd(16'd5);
        chk("rd5", bus.RData, 16'h1234);

        // Loader and processor collide on address 3. The processor data is newer.
        step(16'd3, 1'b1, 16'h5555, 1'b1, 6'd3, 16'hAAAA);
        chk("col3_same", bus.RData, 16'h5555);
        chk("col3_ovr", {15'h0, bus.Overrun}, 16'h0);
        rd(16'd3);
        chk("col3_rd1", bus.RData, 16'h5555);
        rd(16'd3);
        chk("col3_rd2", bus.RData, 16'h5555);

        // Loader writing alone, read in the same cycle.
        step(16'd20, 1'b0, 16'h0, 1'b1, 6'd20, 16'h2020);
        chk("ld20_same", bus.RData, 16'h2020);

        // The pending entry is retained while the loader rewrites the same word.
        step(16'd12, 1'b1, 16'hC0C0, 1'b1, 6'd12, 16'h0C0C);
        chk("ret12_a", bus.RData, 16'hC0C0);
        step(16'd12, 1'b0, 16'h0, 1'b1, 6'd12, 16'hDDDD);
        chk("ret12_b", bus.RData, 16'hC0C0);
        rd(16'd12);
        chk("ret12_c", bus.RData, 16'hC0C0);

        // The pending entry commits while a new processor write refills it.
        step(16'd10, 1'b1, 16'hA0A0, 1'b1, 6'd30, 16'h3030);
        step(16'd11, 1'b1, 16'hB1B1, 1'b0, 6'd0, 16'h0);
        chk("refill11", bus.RData, 16'hB1B1);
        rd(16'd10);
        chk("refill10", bus.RData, 16'hA0A0);
        rd(16'd30);
        chk("ld30", bus.RData, 16'h3030);
        chk("pre_ovr", {15'h0, bus.Overrun}, 16'h0);

        // Two back-to-back collisions. The second processor write is dropped.
        step(16'd7, 1'b1, 16'h0707, 1'b1, 6'd7, 16'h7777);
        step(16'd8, 1'b1, 16'h0808, 1'b1, 6'd8, 16'h8888);
        chk("ovr_set", {15'h0, bus.Overrun}, 16'h1);
        chk("ovr_rd8_same", bus.RData, 16'h8888);
        rd(16'd8);
        chk("ovr_rd8", bus.RData, 16'h8888);
        rd(16'd7);
        chk("ovr_rd7", bus.RData, 16'h0707);

        // An out-of-range write is discarded and flagged.
        chk("pre_aerr", {15'h0, bus.AddrErr}, 16'h0);
        step(16'h0040, 1'b1, 16'hBEEF, 1'b0, 6'd0, 16'h0);
        chk("aerr_set", {15'h0, bus.AddrErr}, 16'h1);
        chk("aerr_rd_same", bus.RData, 16'h0);
        rd(16'h0040);
        chk("aerr_rd40", bus.RData, 16'h0);
        rd(16'h0000);
        chk("aerr_rd0", bus.RData, 16'h0);
        chk("ovr_sticky", {15'h0, bus.Overrun}, 16'h1);

        // Reset partway through the clear sweep.
        rst = 1'b1; rd(16'h0); rst = 1'b0;
        for (int k = 0; k < 30; k++) rd(16'h0);
        chk("midclr_ready", {15'h0, bus.Ready}, 16'h0);
        rst = 1'b1; rd(16'h0); rst = 1'b0;
        chk("midclr_flags", {14'h0, bus.Overrun, bus.AddrErr}, 16'h0);
        clear_and_sweep("midclr");

        // Reset in service after writes, with a pending entry in flight.
        step(16'd9, 1'b1, 16'h9999, 1'b0, 6'd0, 16'h0);
        step(16'd4, 1'b1, 16'h4444, 1'b1, 6'd4, 16'h1111);
        chk("pre_rst_rd4", bus.RData, 16'h4444);
        rst = 1'b1; rd(16'h0); rst = 1'b0;
        chk("serve_rst_ready", {15'h0, bus.Ready}, 16'h0);
        clear_and_sweep("srvrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
